// File: rtl/spi_tx_rx_core.sv
// Mode-0 SPI master on i_clk; bit timing comes from edges of the divider's i_div_clk.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module spi_tx_rx_core #(
  parameter int P_DATA_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_div_clk,
  input  logic [P_DATA_W-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_sclk,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic                o_cs_n,
  output logic [P_DATA_W-1:0] o_rdata,
  output logic                o_rvalid
);

  localparam int CNT_W = $clog2(P_DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t              state, state_nxt;
  logic                div_d;
  logic                rise_evt, fall_evt, last_bit, accept;
  logic [CNT_W-1:0]    bit_cnt;
  logic [P_DATA_W-1:0] tx_sh, rx_sh;
  logic                tx_out;
  logic [P_DATA_W-1:0] tx_next, rx_next;

  // Divider output is already in this clock domain; it is only sampled, never used as a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) div_d <= 1'b0;
    else       div_d <= i_div_clk;
  end

  assign rise_evt = i_div_clk & ~div_d;
  assign fall_evt = ~i_div_clk & div_d;
  assign last_bit = (bit_cnt == LAST_BIT);
  assign accept   = i_valid & o_ready;

`ifdef SPI_LSB_FIRST_EN
  assign tx_out  = tx_sh[0];
  assign tx_next = {1'b0, tx_sh[P_DATA_W-1:1]};
  assign rx_next = {i_miso, rx_sh[P_DATA_W-1:1]};
`else
  assign tx_out  = tx_sh[P_DATA_W-1];
  assign tx_next = {tx_sh[P_DATA_W-2:0], 1'b0};
  assign rx_next = {rx_sh[P_DATA_W-2:0], i_miso};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)               state_nxt = LEAD;
      LEAD:    if (fall_evt)             state_nxt = SHIFT;
      SHIFT:   if (fall_evt && last_bit) state_nxt = TRAIL;
      TRAIL:   if (fall_evt)             state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Chip select and ready both mark the idle state, so they fall and rise together.
  always_comb begin
    o_ready = (state == IDLE);
    o_cs_n  = (state == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      case (state)
        IDLE: if (accept) tx_sh <= i_data;
        LEAD: if (fall_evt) begin
          o_mosi  <= tx_out;
          tx_sh   <= tx_next;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (rise_evt) begin
            o_sclk <= 1'b1;
            rx_sh  <= rx_next;
          end
          // The final falling edge leaves o_mosi holding the last bit.
          if (fall_evt) begin
            o_sclk <= 1'b0;
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 1'b1;
              o_mosi  <= tx_out;
              tx_sh   <= tx_next;
            end
          end
        end
        TRAIL: if (fall_evt) begin
          o_rdata  <= rx_sh;
          o_rvalid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_rx_core.sv
// Self-checking bench for spi_tx_rx_core: transfer-level model counting divider edges per word.
module tb_spi_tx_rx_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_clk = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] data = '0;
  logic         miso;
  logic         ready, sclk, mosi, cs_n, rvalid;
  logic [W-1:0] rdata;

  spi_tx_rx_core #(.P_DATA_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_div_clk(div_clk), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n),
    .o_rdata(rdata), .o_rvalid(rvalid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position in the word of the k-th bit on the wire.
  function automatic int bidx(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return W - 1 - k;
`endif
  endfunction

  function automatic logic mbit(input logic [W-1:0] w, input int k);
    if (k < 0 || k >= W) return 1'b0;
    return w[bidx(k)];
  endfunction

  // Divider: toggles every 'half' cycles (period 2*half), optionally stalling at random.
  int half = 2;
  bit stall_en = 1'b0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!(stall_en && $urandom_range(0, 7) == 0)) begin
        cnt++;
        if (cnt >= half) begin
          cnt = 0;
          div_clk = ~div_clk;
        end
      end
    end
  end

  // Model state
  bit           loop = 1'b1;
  logic [W-1:0] mword = '0;
  bit           busy = 0, exp_sclk = 0, exp_rvalid = 0, rise_now = 0, lp_x = 0;
  int           nf = 0, nr = 0, cs_cnt = 0, acc_cnt = 0, done_cnt = 0, dut_rv_cnt = 0;
  int           cyc = 0, last_rv_cyc = -100, acc_gap = 0;
  logic [W-1:0] word = '0, mw_x = '0, exp_rdata = '0, mosi_seq = '0, rd0 = '0, rd1 = '0;
  bit           p_acc = 0, p_rise = 0, p_fall = 0, last_div = 0;
  logic [W-1:0] p_data = '0;

  assign miso = loop ? mosi : mbit(mword, nr);

  always @(negedge clk) begin
    cyc++;
    if (rvalid === 1'b1) dut_rv_cnt++;
    if (rst) begin
      busy = 0; exp_sclk = 0; exp_rdata = '0; nr = 0; nf = 0; cs_cnt = 0;
      p_acc = 0; p_rise = 0; p_fall = 0; last_div = 0;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_ready", ready, 1);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_rdata", rdata, 0);
    end else begin
      exp_rvalid = 0;
      rise_now = 0;
      if (p_acc) begin
        busy = 1; nf = 0; nr = 0; word = p_data; mw_x = mword; lp_x = loop; mosi_seq = '0;
        acc_cnt++;
        acc_gap = cyc - last_rv_cyc;
      end else if (busy) begin
        // Falls seen so far: 1 ends the lead-in, W more clock the bits, 1 more ends the hold.
        if (p_rise && nf >= 1 && nf <= W) begin
          exp_sclk = 1; nr++; rise_now = 1;
        end
        if (p_fall) begin
          if (nf >= 1 && nf <= W) exp_sclk = 0;
          nf++;
          if (nf == W + 2) begin
            exp_rvalid = 1; busy = 0;
            exp_rdata = lp_x ? word : mw_x;
          end
        end
      end
      chk("sclk", sclk, exp_sclk);
      chk("cs_n", cs_n, !busy);
      chk("ready", ready, !busy);
      chk("rvalid", rvalid, exp_rvalid);
      chk("rdata", rdata, exp_rdata);
      if (rise_now) begin
        chk("mosi_bit", mosi, word[bidx(nr - 1)]);
        mosi_seq = {mosi_seq[W-2:0], mosi};
      end
      if (cs_n === 1'b0) cs_cnt++;
      if (exp_rvalid) begin
        chk("sclk_rises", nr, W);
        if (!stall_en) chk("cs_low_bound", cs_cnt <= (W + 2) * 2 * half, 1);
        cs_cnt = 0;
        done_cnt++;
        last_rv_cyc = cyc;
        rd1 = rd0;
        rd0 = rdata;
      end
      p_acc    = valid && !busy;
      p_data   = data;
      p_rise   = div_clk && !last_div;
      p_fall   = !div_clk && last_div;
      last_div = div_clk;
    end
  end

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_cnt < target && t < 60) begin @(posedge clk); #1; t++; end
    chk("accept_in_time", acc_cnt >= target, 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin @(posedge clk); #1; t++; end
    chk("done_in_time", done_cnt >= target, 1);
  endtask

  task automatic send(input logic [W-1:0] d, input bit lp, input logic [W-1:0] mw);
    int a0, d0;
    loop = lp; mword = mw; data = d;
    a0 = acc_cnt; d0 = done_cnt;
    valid = 1'b1;
    wait_acc(a0 + 1);
    valid = 1'b0;
    wait_done(d0 + 1);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_cs_n", cs_n, 1);
    chk("async_sclk", sclk, 0);
    chk("async_ready", ready, 1);
    chk("async_rvalid", rvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int a0, d0, t, rv0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Loopback 0xA5 with divider period 4
    half = 2;
    send(8'hA5, 1'b1, 8'h00);
    chk("a5_mosi_seq", mosi_seq, 8'hA5);
    chk("a5_rdata", rdata, 8'hA5);

    // Fixed MISO high, transmit zeros
    send(8'h00, 1'b0, 8'hFF);
    chk("zero_mosi_seq", mosi_seq, 8'h00);
    chk("ff_rdata", rdata, 8'hFF);

    // Back-to-back with i_valid held high
    loop = 1'b1; data = 8'h3C; valid = 1'b1;
    a0 = acc_cnt; d0 = done_cnt;
    wait_acc(a0 + 1);
    data = 8'hC3;
    wait_acc(a0 + 2);
    valid = 1'b0;
    chk("b2b_accept_gap", acc_gap, 1);
    wait_done(d0 + 2);
    chk("b2b_first", rd1, 8'h3C);
    chk("b2b_second", rd0, 8'hC3);

    // Reset after the 4th sclk rise of 0xFF
    loop = 1'b1; data = 8'hFF; valid = 1'b1;
    wait_acc(acc_cnt + 1);
    valid = 1'b0;
    t = 0;
    while (!(nr == 4 && exp_sclk) && t < 500) begin @(posedge clk); #1; t++; end
    chk("reached_4th_rise", nr == 4, 1);
    rv0 = dut_rv_cnt;
    async_reset_check();
    repeat (30) @(posedge clk);
    #1;
    chk("no_rvalid_after_rst", dut_rv_cnt, rv0);
    chk("rdata_zero_after_rst", rdata, 8'h00);
    send(8'h81, 1'b1, 8'h00);
    chk("post_rst_rdata", rdata, 8'h81);

    // Single set bit shows transmit order
    send(8'h01, 1'b1, 8'h00);
`ifdef SPI_LSB_FIRST_EN
    chk("one_mosi_seq", mosi_seq, 8'h80);
`else
    chk("one_mosi_seq", mosi_seq, 8'h01);
`endif
    chk("one_rdata", rdata, 8'h01);

    // Randomized transfers, varying divider rate, gaps and stalls
    for (int i = 0; i < 40; i++) begin
      half = $urandom_range(1, 3);
      stall_en = (i >= 25);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      send(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom));
    end
    stall_en = 1'b0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_tx_rx_core.md
Name: spi_tx_rx_core

Overview:
- Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0) directly downstream of the clock divider.
- Consumes the divider's square-wave output as a bit-rate reference.
- All logic runs on the fast system clock i_clk. The divided clock is used only as data and edge-detected into single-cycle enables; it never clocks a flop.
- Presents a valid/ready word interface to upstream control logic and returns the received word with a one-cycle valid strobe.

Parameters:
- P_DATA_W, 8, word width in bits per transfer. Legal range 2..32.

Ports:
- i_clk  input  1  system clock; same domain as the divider output.
- i_rst  input  1  asynchronous reset, active-high.
- i_div_clk  input  1  divided clock from the clock divider. Registered in the i_clk domain, so no synchronizer.
- i_data  input  P_DATA_W  transmit word.
- i_valid  input  1  transmit request.
- o_ready  output  1  core idle, accepts i_data.
- o_sclk  output  1  SPI serial clock.
- o_mosi  output  1  SPI master-out data.
- i_miso  input  1  SPI master-in data.
- o_cs_n  output  1  SPI chip select, active-low.
- o_rdata  output  P_DATA_W  last received word.
- o_rvalid  output  1  one-cycle strobe, o_rdata updated.

Behaviour:
- Reset values: o_ready=1, o_sclk=0, o_mosi=0, o_cs_n=1, o_rdata=0, o_rvalid=0, state=IDLE, bit counter=0, both shift registers=0.
- Edge detect:
  - r_div_d <= i_div_clk every cycle.
  - rise_evt = i_div_clk & ~r_div_d.
  - fall_evt = ~i_div_clk & r_div_d.
  - Events are combinational, one i_clk cycle wide.
  - The r_div_d reset value is 0, so a divider already high at reset release produces one rise_evt, which is harmless in IDLE.
- States:
  - IDLE:
    - o_ready=1.
    - On i_valid & o_ready: tx shift <= i_data, o_cs_n <= 0, o_ready <= 0, go to LEAD.
    - i_valid while not ready is ignored; there is no queuing.
  - LEAD:
    - Wait for fall_evt.
    - Then o_mosi <= first bit (MSB), bit_cnt <= 0, go to SHIFT.
    - rise_evt in LEAD is ignored.
  - SHIFT on rise_evt: o_sclk <= 1, rx shift <= {rx[P_DATA_W-2:0], i_miso}.
  - SHIFT on fall_evt:
    - o_sclk <= 0.
    - If bit_cnt == P_DATA_W-1, go to TRAIL.
    - Otherwise bit_cnt++ and o_mosi <= next bit.
  - TRAIL:
    - Wait for the next fall_evt, which gives one full divider period of CS hold.
    - Then o_cs_n <= 1, o_rdata <= rx shift, o_rvalid <= 1 for exactly one cycle, o_ready <= 1, go to IDLE.
- Each transfer produces exactly P_DATA_W rising edges on o_sclk. o_sclk is low in IDLE, LEAD and TRAIL.
- o_mosi holds its last bit after a transfer until the next LEAD fall_evt.
- Bit counter width is clog2(P_DATA_W). Its compare uses P_DATA_W-1, so the counter does not wrap.
- Back-to-back:
  - A new i_valid may be accepted in the cycle after o_rvalid, because o_ready is high there.
  - The minimum gap between CS deassert and reassert is 1 i_clk cycle.
- Divider period: with a divider count of N, one SPI bit takes (2*((N>>1)+1)) i_clk cycles.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously). No o_rvalid is issued, and the partial rx word is discarded.
- If i_div_clk stalls, the core stays in its current state. There is no timeout.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined:
  - Transmit order is LSB first: tx shifts right and o_mosi = tx[0].
  - Receive shifts into the MSB: rx <= {i_miso, rx[P_DATA_W-1:1]}.
  - o_rdata is bit-aligned to i_data.
- Undefined (default): MSB first, as described in Behaviour.

Test Plan:
- Reset:
  - Assert i_rst mid-simulation with the divider count at 2 (divider period = 4 cycles).
  - Required: o_cs_n=1, o_sclk=0, o_ready=1, o_rvalid=0 in the same cycle, asynchronously.
- Loopback:
  - i_miso tied to o_mosi, send i_data=0xA5.
  - Required: 8 o_sclk rising edges, o_cs_n low throughout, MOSI sequence 1,0,1,0,0,1,0,1, o_rdata=0xA5 with a single o_rvalid pulse.
  - With a divider period of 4, o_cs_n stays low for ≤ 4+32+4 cycles.
- Fixed MISO:
  - Drive i_miso=1, send 0x00.
  - Required: o_mosi=0 on every bit, o_rdata=0xFF.
- Busy and back-to-back:
  - Hold i_valid high with data 0x3C then 0xC3.
  - Required: the second word is accepted only in the cycle after the first o_rvalid, o_cs_n goes high for ≥1 cycle between words, rdata sequence (loopback) = 0x3C then 0xC3.
- Reset mid-word:
  - Assert i_rst after the 4th sclk rise of a 0xFF transfer.
  - Required: no o_rvalid, o_rdata stays 0x00, and the next transfer of 0x81 completes correctly.
- SPI_LSB_FIRST_EN defined, loopback 0x01:
  - Required: the first MOSI bit is 1, then seven 0s, and o_rdata=0x01.
